fetch_unit: RTL and testbench

Instruction fetch stage of the single-stage RISC core. Owns the program counter and issues one word request at a time to instruction memory. Presents the returned instruction, with its PC, to the decode/control path through a valid/ready handshake; `instr[6:0]` is the opcode consumed by the control unit. Accepts PC redirects from branch resolution and squashes stale fetches.

---
 rtl/core_pkg.sv | 32 +++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: widths, the NOP encoding, opcodes consumed by the
// control unit, and the fetch FSM state type.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handshake.
// The master side is the fetch unit; the slave side is memory and decode.
interface fetch_unit_if #(
  parameter int unsigned XLEN = core_pkg::XLEN
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, and
// hands each returned word to decode; redirects squash in-flight fetches.
module fetch_unit #(
  parameter int unsigned          XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    bus
);
  import core_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;

  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_seq;
  fetch_state_t    park_state;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign pc_seq       = pc_q + XLEN'(4);
  assign park_state   = fetch_en ? REQ : IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Next-state, PC mux and output-register inputs; redirect wins everywhere.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    unique case (state_q)
      IDLE: begin
        if (redirect) pc_d = redirect_tgt;
        if (fetch_en) state_d = REQ;
      end
      REQ: begin
        if (redirect) pc_d = redirect_tgt;
        if (bus.imem_gnt) begin
          state_d = WAIT;
          if (redirect) kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (redirect) pc_d = redirect_tgt;
        if (bus.imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = park_state;
          end else begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          pc_d          = redirect ? redirect_tgt : pc_seq;
          instr_valid_d = 1'b0;
          state_d       = park_state;
        end else if (redirect) begin
          pc_d          = redirect_tgt;
          instr_valid_d = 1'b0;
          state_d       = park_state;
        end
      end
      default: state_d = IDLE;
    endcase

    imem_req_d  = (state_d == REQ);
    imem_addr_d = pc_d;
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ: grant now, respond next cycle, end in HOLD.
  task automatic fetch_word(input logic [31:0] data);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    step();
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic consume();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    fetch_en        = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    repeat (3) step();

    check("rst_req",   32'(bus.imem_req),    32'd0);
    check("rst_addr",  bus.imem_addr,        32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr,            32'h0000_0013);
    check("rst_ipc",   bus.instr_pc,         32'h0);

    // cycle 0: release reset, enable fetch
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    step();
    check("c1_req",  32'(bus.imem_req), 32'd1);
    check("c1_addr", bus.imem_addr,     32'h0);
    bus.imem_gnt = 1'b1;
    step();
    check("c2_req", 32'(bus.imem_req), 32'd0);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0050_0093;
    step();
    bus.imem_rvalid = 1'b0;
    check("c3_valid", 32'(bus.instr_valid), 32'd1);
    check("c3_instr", bus.instr,            32'h0050_0093);
    check("c3_ipc",   bus.instr_pc,         32'h0);

    // backpressure: hold for 5 cycles
    bus.imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_instr", bus.instr,            32'h0050_0093);
      check("bp_req",   32'(bus.imem_req),    32'd0);
    end
    consume();
    check("seq_req",   32'(bus.imem_req),    32'd1);
    check("seq_addr",  bus.imem_addr,        32'h4);
    check("seq_valid", 32'(bus.instr_valid), 32'd0);

    // walk to PC 0x10, then redirect together with consumption
    fetch_word(32'h0000_0013); consume();
    fetch_word(32'h0000_0013); consume();
    fetch_word(32'h0000_0013); consume();
    check("walk_addr", bus.imem_addr, 32'h10);
    fetch_word(32'h0010_0113);
    check("h10_ipc",   bus.instr_pc, 32'h10);
    check("h10_instr", bus.instr,    32'h0010_0113);
    bus.instr_ready = 1'b1;
    redirect        = 1'b1;
    redirect_pc     = 32'h103;
    step();
    bus.instr_ready = 1'b0;
    redirect        = 1'b0;
    check("rdc_req",  32'(bus.imem_req), 32'd1);
    check("rdc_addr", bus.imem_addr,     32'h100);

    // redirect while in WAIT, response arrives afterwards
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    redirect     = 1'b1;
    redirect_pc  = 32'h200;
    step();
    redirect = 1'b0;
    check("rdw_req",   32'(bus.imem_req),    32'd0);
    check("rdw_valid", 32'(bus.instr_valid), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    check("rdw_valid2", 32'(bus.instr_valid), 32'd0);
    check("rdw_req2",   32'(bus.imem_req),    32'd1);
    check("rdw_addr",   bus.imem_addr,        32'h200);

    // response and redirect in the same WAIT cycle
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1111_1111;
    redirect        = 1'b1;
    redirect_pc     = 32'h300;
    step();
    bus.imem_rvalid = 1'b0;
    redirect        = 1'b0;
    check("same_valid", 32'(bus.instr_valid), 32'd0);
    check("same_addr",  bus.imem_addr,        32'h300);

    // grant stall
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_req",  32'(bus.imem_req), 32'd1);
      check("stall_addr", bus.imem_addr,     32'h300);
    end

    // redirect in REQ without grant, then with grant (kill path)
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    step();
    check("rqr_req",  32'(bus.imem_req), 32'd1);
    check("rqr_addr", bus.imem_addr,     32'h400);
    bus.imem_gnt = 1'b1;
    redirect_pc  = 32'h502;
    step();
    bus.imem_gnt    = 1'b0;
    redirect        = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h2222_2222;
    step();
    bus.imem_rvalid = 1'b0;
    check("kill_valid", 32'(bus.instr_valid), 32'd0);
    check("kill_addr",  bus.imem_addr,        32'h500);

    // PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    fetch_word(32'h0000_0033);
    check("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    consume();
    check("wrap_addr", bus.imem_addr, 32'h0);

    // fetch_en drop during a granted request: completes, then parks
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    fetch_en        = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0063;
    step();
    bus.imem_rvalid = 1'b0;
    check("park_valid", 32'(bus.instr_valid), 32'd1);
    check("park_instr", bus.instr,            32'h0000_0063);
    consume();
    check("idle_req", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h3333_3333;
    redirect        = 1'b1;
    redirect_pc     = 32'h600;
    step();
    bus.imem_rvalid = 1'b0;
    redirect        = 1'b0;
    check("stray_valid", 32'(bus.instr_valid), 32'd0);
    check("idle_req2",   32'(bus.imem_req),    32'd0);
    fetch_en = 1'b1;
    step();
    check("idle_rd_req",  32'(bus.imem_req), 32'd1);
    check("idle_rd_addr", bus.imem_addr,     32'h600);

    // reset mid-fetch, then a late response
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    rst_n        = 1'b0;
    #2;
    check("mrst_req",   32'(bus.imem_req),    32'd0);
    check("mrst_valid", 32'(bus.instr_valid), 32'd0);
    check("mrst_instr", bus.instr,            32'h0000_0013);
    step();
    rst_n           = 1'b1;
    fetch_en        = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    check("late_valid", 32'(bus.instr_valid), 32'd0);
    check("late_instr", bus.instr,            32'h0000_0013);
    check("late_req",   32'(bus.imem_req),    32'd0);
    check("late_addr",  bus.imem_addr,        32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
